// File: rtl/fmc_i2c_arbiter.sv
// rtl/fmc_i2c_arbiter.sv - round-robin arbiter sharing one I2C byte master among NREQ requesters
// Optional WAIT timeout is compiled in with `define FMC_I2C_ARB_TIMEOUT_EN.
module fmc_i2c_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [8*NREQ-1:0]   req_wdata,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_err,
    output logic [NREQ-1:0]     grant,
    output logic                m_valid,
    output logic                m_start,
    output logic                m_stop,
    output logic [6:0]          m_addr,
    output logic                m_rw,
    output logic [7:0]          m_wdata,
    input  logic                m_ready,
    input  logic                m_done,
    input  logic [7:0]          m_rdata,
    input  logic                m_nack
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("fmc_i2c_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t        state;
    logic [IW-1:0] win;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] next_win;
    logic          found;
    logic          first;
    logic          last_byte;
    int            rr_idx;

`ifdef FMC_I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        next_win = '0;
        found    = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = int'(last_grant) + k;
            if (rr_idx >= NREQ)
                rr_idx = rr_idx - NREQ;
            if (!found && req_valid[rr_idx[IW-1:0]]) begin
                found    = 1'b1;
                next_win = rr_idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NREQ - 1);
            win        <= '0;
            first      <= 1'b0;
            last_byte  <= 1'b0;
            m_valid    <= 1'b0;
            m_start    <= 1'b0;
            m_stop     <= 1'b0;
            m_addr     <= '0;
            m_rw       <= 1'b0;
            m_wdata    <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef FMC_I2C_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    grant <= '0;
                    if (found) begin
                        win   <= next_win;
                        grant <= onehot(next_win);
                        first <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_valid && m_ready) begin
                        req_ready <= onehot(win);
                        last_byte <= m_stop;
                        first     <= 1'b0;
                        m_valid   <= 1'b0;
                        m_start   <= 1'b0;
                        m_stop    <= 1'b0;
                        state     <= WAIT;
`ifdef FMC_I2C_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else begin
                        // Track the owner's request live; a withdrawn byte simply drops m_valid.
                        m_valid <= req_valid[win];
                        m_start <= first;
                        m_stop  <= req_last[win];
                        m_addr  <= req_addr[int'(win)*7 +: 7];
                        m_rw    <= req_rw[win];
                        m_wdata <= req_wdata[int'(win)*8 +: 8];
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        rsp_valid <= onehot(win);
                        rsp_rdata <= m_rdata;
                        rsp_err   <= m_nack;
                        state     <= (last_byte || m_nack) ? RELEASE : ISSUE;
                    end
`ifdef FMC_I2C_ARB_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= onehot(win);
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                RELEASE: begin
                    grant      <= '0;
                    last_grant <= win;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
